stereo_tone_source: RTL and testbench
=====================================

// Module: stereo_tone_source
// PURPOSE
//  Stereo DDS tone generator; the sample source directly upstream of the sample FIFO feeding i2s_master.
//  Produces one {left,right} 2*DW-bit sample per sample_tick.
//  Uses per-channel phase accumulators and a quarter-wave sine ROM with per-channel attenuation.
//  Output is a valid/ready stream that connects straight to the FIFO write side: out_valid -> i_wr, !o_full -> out_ready.
// PARAMETERS
//  DW      24  sample width per channel, two's complement
//  PW      32  phase accumulator width
//  LUT_AW   8  quarter-wave ROM address width (2**LUT_AW entries)
// PORTS
//  clk            in   1        system clock
//  arst_n         in   1        reset, asynchronous, active-low
//  enable         in   1        1 = accept sample_tick
//  sample_tick    in   1        one-cycle pulse at audio sample rate
//  freq_l         in   PW       left phase increment per sample
//  freq_r         in   PW       right phase increment per sample
//  atten_l        in   4        left arithmetic right-shift amount, 0..15
//  atten_r        in   4        right arithmetic right-shift amount, 0..15
//  out_data       out  2*DW     {left[2*DW-1:DW], right[DW-1:0]}
//  out_valid      out  1        out_data holds an unconsumed sample
//  out_ready      in   1        consumer accepts when out_valid & out_ready
//  overrun        out  1        sticky: a sample_tick was dropped
//  clear_overrun  in   1        synchronous clear of overrun
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE, phase_l=phase_r=0, out_data=0, out_valid=0, overrun=0.
//  - FSM states and transitions:
//    - IDLE: on sample_tick & enable, latch freq_*/atten_* and go to RD_L.
//    - RD_L: register ROM read for phase_l; go to RD_R.
//    - RD_R: register ROM read for phase_r; go to SCALE.
//    - SCALE: apply sign and attenuation, load out_data, set out_valid=1; go to OUT.
//    - OUT: hold until out_valid & out_ready. On that edge: out_valid=0, phase_l+=freq_l, phase_r+=freq_r (mod 2**PW); go to IDLE.
//  - Latency: tick sampled at edge N -> out_valid high after edge N+3. out_valid can therefore never rise on the tick cycle.
//  - out_data is stable while out_valid=1 and out_ready=0. out_data keeps its last value after the handshake.
//  - Sine lookup per channel:
//    - q = phase[PW-1:PW-2]; idx = phase[PW-3:PW-2-LUT_AW].
//    - addr = q[0] ? ~idx : idx.
//    - mag = ROM[addr] = round((2**(DW-1)-1)*sin(pi/2*(addr+0.5)/2**LUT_AW)).
//    - value = q[1] ? -mag : mag. No overflow is possible, since mag < 2**(DW-1).
//  - Attenuation: value >>> atten (sign-extending). atten=0 passes the value unchanged.
//  - Samples are computed from the current phase; the phase advances only on a completed handshake.
//  - sample_tick while FSM != IDLE, or in IDLE with enable=0: the tick is dropped.
//  - Dropped tick when not IDLE: overrun is set. A tick with enable=0 does not set overrun.
//  - Simultaneous set and clear_overrun: set wins.
//  - Tick in the same cycle as the OUT handshake: the tick is dropped and overrun is set, because the FSM is not yet IDLE.
//  - Deasserting enable mid-sample does not abort it; the current sample completes and is handed over.
//  - freq/atten changes take effect at the next accepted tick.
//  - PW < LUT_AW+2 is illegal; flag it with an elaboration-time error.
// TESTING
//  1. freq_l=freq_r=0, atten=0, tick, out_ready=1 -> out_data={24'h006488,24'h006488} three edges after tick; phases stay 0.
//  2. freq_l=32'h4000_0000, atten_l=0, 4 ticks -> left = +25736, +8388568, -25736, -8388568; fifth tick repeats +25736.
//  3. As test 2 with atten_l=4, freq_r=0, atten_r=15 -> first sample left=1608, right=0.
//  4. out_ready=0, two ticks 20 cycles apart -> out_data unchanged, overrun=1.
//     Then out_ready=1 -> one handshake; phase advanced once only; clear_overrun -> overrun=0.
//  5. Tick asserted on the handshake cycle -> tick dropped, overrun=1. enable=0 with a tick -> no output, overrun unchanged.
//  6. Pulse arst_n low during RD_R -> out_valid=0 and out_data=0 immediately; the next tick yields the phase-0 sample after 3 edges.

Source files
------------

// File: rtl/stereo_tone_source.sv
// Stereo DDS tone source: per-channel phase accumulators and a shared quarter-wave sine ROM.
// Each accepted sample_tick yields one {left,right} sample on a valid/ready output.
module stereo_tone_source #(
  parameter int DW     = 24,
  parameter int PW     = 32,
  parameter int LUT_AW = 8
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            enable,
  input  logic            sample_tick,
  input  logic [PW-1:0]   freq_l,
  input  logic [PW-1:0]   freq_r,
  input  logic [3:0]      atten_l,
  input  logic [3:0]      atten_r,
  output logic [2*DW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overrun,
  input  logic            clear_overrun
);
  localparam int ROM_N = 2**LUT_AW;
  typedef logic [ROM_N-1:0][DW-2:0] rom_t;
  typedef enum logic [2:0] {IDLE, RD_L, RD_R, SCALE, OUT} state_t;

  if (PW < LUT_AW + 2) begin : g_bad_pw
    $error("stereo_tone_source: PW must be at least LUT_AW+2");
  end

  // Quarter-wave magnitudes sampled at bin centres so the table mirrors cleanly.
  function automatic rom_t build_rom();
    rom_t r;
    real  amp;
    real  ang;
    amp = real'((longint'(1) << (DW - 1)) - 1);
    r   = '0;
    for (int i = 0; i < ROM_N; i++) begin
      ang  = 3.141592653589793 / 2.0 * (real'(i) + 0.5) / real'(ROM_N);
      r[i] = (DW-1)'($rtoi(amp * $sin(ang) + 0.5));
    end
    return r;
  endfunction

  localparam rom_t ROM = build_rom();

  state_t                 state;
  logic [1:0][PW-1:0]     phase;
  logic [1:0][PW-1:0]     freq;
  logic [1:0][3:0]        atten;
  logic [1:0][DW-2:0]     mag;
  logic [1:0]             neg;
  logic [1:0][DW-1:0]     scaled;
  logic [LUT_AW+1:0]      rd_top;
  logic [LUT_AW-1:0]      rd_addr;

  // Channel index 1 is left, 0 is right, matching the out_data packing.
  assign rd_top  = (state == RD_L) ? phase[1][PW-1 -: LUT_AW+2] : phase[0][PW-1 -: LUT_AW+2];
  assign rd_addr = rd_top[LUT_AW] ? ~rd_top[LUT_AW-1:0] : rd_top[LUT_AW-1:0];

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic signed [DW-1:0] val;
    assign val        = neg[ch] ? -$signed({1'b0, mag[ch]}) : $signed({1'b0, mag[ch]});
    assign scaled[ch] = val >>> atten[ch];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      phase     <= '0;
      freq      <= '0;
      atten     <= '0;
      mag       <= '0;
      neg       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // A tick that lands on the handshake edge is still a drop: state is OUT then.
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      else if (clear_overrun)           overrun <= 1'b0;

      case (state)
        IDLE: if (sample_tick && enable) begin
          freq  <= {freq_l, freq_r};
          atten <= {atten_l, atten_r};
          state <= RD_L;
        end
        RD_L: begin
          mag[1] <= ROM[rd_addr];
          neg[1] <= rd_top[LUT_AW+1];
          state  <= RD_R;
        end
        RD_R: begin
          mag[0] <= ROM[rd_addr];
          neg[0] <= rd_top[LUT_AW+1];
          state  <= SCALE;
        end
        SCALE: begin
          out_data  <= scaled;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          phase[1]  <= phase[1] + freq[1];
          phase[0]  <= phase[0] + freq[0];
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stereo_tone_source.sv
// Scoreboard bench for stereo_tone_source: a sample-level model pushes expected samples on
// accepted ticks, a negedge monitor pops them on every output handshake.
module tb_stereo_tone_source;
  logic        clk = 1'b0;
  logic        arst_n, enable, sample_tick, out_ready, clear_overrun;
  logic [31:0] freq_l, freq_r;
  logic [3:0]  atten_l, atten_r;
  logic [47:0] out_data;
  logic        out_valid, overrun;

  int checks = 0;
  int errors = 0;

  stereo_tone_source #(.DW(24), .PW(32), .LUT_AW(8)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .sample_tick(sample_tick),
    .freq_l(freq_l), .freq_r(freq_r), .atten_l(atten_l), .atten_r(atten_r),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int sine_ref(input bit [31:0] ph);
    int  a;
    int  m;
    real s;
    a = int'(ph[29:22]);
    if (ph[30]) a = 255 - a;
    s = 8388607.0 * $sin(3.141592653589793 / 2.0 * (real'(a) + 0.5) / 256.0);
    m = $rtoi(s + 0.5);
    return ph[31] ? -m : m;
  endfunction

  function automatic logic [47:0] exp_sample(input bit [31:0] pl, input bit [31:0] pr,
                                             input bit [3:0] al, input bit [3:0] ar);
    int          v;
    logic [23:0] l, r;
    v = sine_ref(pl) >>> al;
    l = v[23:0];
    v = sine_ref(pr) >>> ar;
    r = v[23:0];
    return {l, r};
  endfunction

  // Reference model: a sample is "in flight" from its accepted tick until the handshake,
  // which can happen no earlier than four edges after the tick.
  logic [47:0] sb[$];
  bit          busy = 0, exp_ovr = 0, exp_valid = 0;
  int unsigned edge_n = 0, acc_edge = 0;
  bit [31:0]   mph_l = 0, mph_r = 0, mfr_l = 0, mfr_r = 0;

  initial begin
    bit hs;
    forever begin
      @(posedge clk or negedge arst_n);
      if (!arst_n) begin
        busy = 0; mph_l = 0; mph_r = 0; exp_ovr = 0; exp_valid = 0;
        sb.delete();
      end else begin
        edge_n++;
        hs = busy && (edge_n - 1 >= acc_edge + 3) && out_ready;
        if (sample_tick && busy) exp_ovr = 1;
        else if (clear_overrun)  exp_ovr = 0;
        if (hs) begin
          busy  = 0;
          mph_l = mph_l + mfr_l;
          mph_r = mph_r + mfr_r;
        end else if (sample_tick && enable && !busy) begin
          busy     = 1;
          acc_edge = edge_n;
          mfr_l    = freq_l;
          mfr_r    = freq_r;
          sb.push_back(exp_sample(mph_l, mph_r, atten_l, atten_r));
        end
        exp_valid = busy && (edge_n >= acc_edge + 3);
      end
    end
  end

  // Monitor
  initial begin
    bit          hold = 0;
    logic [47:0] held = '0;
    forever begin
      @(negedge clk);
      if (arst_n === 1'b1) begin
        chk("valid", out_valid, exp_valid);
        chk("overrun", overrun, exp_ovr);
        if (hold && out_valid) chk("hold_stable", out_data, held);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow actual=handshake required=no_output");
          end else chk("sample", out_data, sb.pop_front());
        end
        hold = out_valid && !out_ready;
        held = out_data;
      end else hold = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
  endtask

  task automatic tick_expect(input string nm, input logic [47:0] exp);
    pulse_tick();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk(nm, out_data, exp);
    cyc(2);
  endtask

  initial begin
    arst_n = 1'b0; enable = 1'b1; sample_tick = 1'b0; out_ready = 1'b1; clear_overrun = 1'b0;
    freq_l = '0; freq_r = '0; atten_l = '0; atten_r = '0;
    cyc(3);
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 48'h0);
    chk("rst_overrun", overrun, 1'b0);
    arst_n = 1'b1;
    cyc(2);

    // zero frequency: phase-0 sample, phases stay put
    tick_expect("t1", {24'h006488, 24'h006488});
    tick_expect("t1_again", {24'h006488, 24'h006488});

    // quarter-turn steps on the left channel
    freq_l = 32'h4000_0000;
    tick_expect("t2_0", {24'h006488, 24'h006488});
    tick_expect("t2_1", {24'h7FFFD8, 24'h006488});
    tick_expect("t2_2", {24'hFF9B78, 24'h006488});
    tick_expect("t2_3", {24'h800028, 24'h006488});
    tick_expect("t2_4", {24'h006488, 24'h006488});

    arst_n = 1'b0;
    cyc(2);
    arst_n = 1'b1;
    cyc(1);
    atten_l = 4'd4; atten_r = 4'd15;
    tick_expect("t3", {24'd1608, 24'd0});
    atten_l = 4'd0; atten_r = 4'd0;

    // backpressure: second tick dropped, one handshake only
    out_ready = 1'b0;
    pulse_tick();
    cyc(20);
    pulse_tick();
    @(negedge clk);
    chk("t4_overrun", overrun, 1'b1);
    chk("t4_hold", out_data, {24'h7FFFD8, 24'h006488});
    #1;
    cyc(1);
    out_ready = 1'b1;
    cyc(3);
    clear_overrun = 1'b1;
    cyc(1);
    clear_overrun = 1'b0;
    @(negedge clk);
    chk("t4_cleared", overrun, 1'b0);
    #1;
    cyc(1);
    tick_expect("t4_next", {24'hFF9B78, 24'h006488});

    // tick on the handshake edge is dropped
    out_ready = 1'b0;
    pulse_tick();
    cyc(3);
    out_ready = 1'b1; sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    @(negedge clk);
    chk("t5_overrun", overrun, 1'b1);
    chk("t5_valid", out_valid, 1'b0);
    #1;
    cyc(5);
    chk("t5_dropped", out_valid, 1'b0);
    clear_overrun = 1'b1;
    cyc(1);
    clear_overrun = 1'b0;
    enable = 1'b0;
    pulse_tick();
    cyc(6);
    chk("t5_disabled_valid", out_valid, 1'b0);
    chk("t5_disabled_ovr", overrun, 1'b0);
    enable = 1'b1;

    // async reset in the middle of a sample
    pulse_tick();
    cyc(1);
    arst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_data", out_data, 48'h0);
    #1;
    arst_n = 1'b1;
    cyc(1);
    tick_expect("t6_after", {24'h006488, 24'h006488});

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      freq_l        = $urandom;
      freq_r        = $urandom;
      atten_l       = 4'($urandom_range(0, 15));
      atten_r       = 4'($urandom_range(0, 15));
      enable        = ($urandom_range(0, 7) != 0);
      sample_tick   = ($urandom_range(0, 5) == 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      clear_overrun = ($urandom_range(0, 9) == 0);
      cyc(1);
    end
    sample_tick = 1'b0; clear_overrun = 1'b0; out_ready = 1'b1;
    cyc(10);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
